// File: rtl/tetris_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tetris_pkg                                                       |
// | Purpose : Shared timing defaults, button index enumeration and a counter   |
// |           width helper for the move-control path.                          |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tetris_pkg;

  // Defaults sized for a 50 MHz clock.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_GRAVITY_TICKS   = 25000000;
  localparam int DEF_REPEAT_DELAY    = 15000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  localparam int NUM_BTNS = 4;

  // Bit position of each button in every 4-bit button vector.
  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } btn_e;

  // Bits needed to hold values 0..maxVal (never less than one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : btn_debounce                                                     |
// | Purpose : 2-flop synchronizer, consecutive-sample debounce counter and     |
// |           registered press (0->1) pulse for one raw push button.           |
// | Ports   : clk, reset  - clock, synchronous active-high reset               |
// |           i_btnRaw    - asynchronous raw button, active-high               |
// |           o_level     - debounced button level                             |
// |           o_press     - one-cycle pulse on each debounced 0->1 change      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module btn_debounce
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btnRaw,
  output logic o_level,
  output logic o_press
);

  localparam int c_CNT_W = cntWidth(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_press;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btnRaw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        // The sample that completes the run flips the level directly, so the
        // press pulse appears alongside the new level with no extra stage.
        if (r_cnt == c_CNT_LAST) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : move_ctrl                                                        |
// | Purpose : Turns four raw buttons plus a gravity timer into prioritised,    |
// |           registered single-cycle move pulses, with auto-repeat on         |
// |           left/right/down and a pause that freezes move generation.        |
// | Ports   : clk, reset             - clock, synchronous active-high reset    |
// |           btn_left/right/up/down - raw asynchronous buttons, active-high   |
// |           pause                  - freezes move generation when high       |
// |           leftSignal/rightSignal/upSignal/downSignal - move pulses         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module move_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GRAVITY_TICKS   = DEF_GRAVITY_TICKS,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  input  logic pause,
  output logic leftSignal,
  output logic rightSignal,
  output logic upSignal,
  output logic downSignal
);

  localparam int c_GRAV_W = cntWidth(GRAVITY_TICKS - 1);
  localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_RPT_W = cntWidth(c_RPT_MAX - 1);
  localparam logic [c_GRAV_W-1:0] c_GRAV_LAST = c_GRAV_W'(GRAVITY_TICKS - 1);
  localparam logic [c_RPT_W-1:0]  c_RPT_FIRST = c_RPT_W'(REPEAT_DELAY - 1);
  localparam logic [c_RPT_W-1:0]  c_RPT_NEXT  = c_RPT_W'(REPEAT_RATE - 1);

  // Every 4-bit button vector is indexed by btn_e.
  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_press;
  logic [NUM_BTNS-1:0] w_rptEvt;
  logic [NUM_BTNS-1:0] w_evt;
  logic [NUM_BTNS-1:0] w_grant;
  logic [NUM_BTNS-1:0] w_outNext;
  logic [NUM_BTNS-1:0] r_out;

  logic [c_GRAV_W-1:0] r_gravCnt;
  logic                r_gravPend;
  logic                w_pendNext;
  logic                w_wrap;

  assign w_raw = {btn_down, btn_up, btn_right, btn_left};

  generate
    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
      // Up is a rotate: it never auto-repeats. Its counter is kept for
      // uniformity and is removed by synthesis because its event is masked.
      localparam logic c_REPEATS = (b != int'(UP));

      logic [c_RPT_W-1:0] r_rptCnt;

      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .i_btnRaw(w_raw[b]),
        .o_level (w_level[b]),
        .o_press (w_press[b])
      );

      // Down-counter to the next repeat. A press restarts it even while
      // paused; it only advances while held and unpaused.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rptCnt <= '0;
        end else if (w_press[b]) begin
          r_rptCnt <= c_RPT_FIRST;
        end else if (!w_level[b]) begin
          r_rptCnt <= '0;
        end else if (!pause) begin
          r_rptCnt <= (r_rptCnt == '0) ? c_RPT_NEXT : r_rptCnt - 1'b1;
        end
      end

      assign w_rptEvt[b] = c_REPEATS & w_level[b] & ~w_press[b] & ~pause &
                           (r_rptCnt == '0);
    end
  endgenerate

  assign w_evt  = pause ? '0 : (w_press | w_rptEvt);
  assign w_wrap = ~pause & (r_gravCnt == c_GRAV_LAST);

  // Fixed priority; losers are simply dropped.
  always_comb begin
    w_grant = '0;
    if (w_evt[LEFT]) begin
      w_grant[LEFT] = 1'b1;
    end else if (w_evt[RIGHT]) begin
      w_grant[RIGHT] = 1'b1;
    end else if (w_evt[DOWN]) begin
      w_grant[DOWN] = 1'b1;
    end else if (w_evt[UP]) begin
      w_grant[UP] = 1'b1;
    end
  end

  // A gravity move (this cycle's wrap or an earlier pending one) takes any
  // cycle without a button grant; a granted button down satisfies it.
  always_comb begin
    w_outNext  = '0;
    w_pendNext = r_gravPend;
    if (!pause) begin
      if (|w_grant) begin
        w_outNext = w_grant;
        if (w_grant[DOWN]) begin
          w_pendNext = 1'b0;
        end else if (w_wrap) begin
          w_pendNext = 1'b1;
        end
      end else begin
        w_outNext[DOWN] = r_gravPend | w_wrap;
        w_pendNext      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out      <= '0;
      r_gravCnt  <= '0;
      r_gravPend <= 1'b0;
    end else begin
      r_out      <= w_outNext;
      r_gravPend <= w_pendNext;
      if (!pause) begin
        r_gravCnt <= w_wrap ? '0 : r_gravCnt + 1'b1;
      end
    end
  end

  assign leftSignal  = r_out[LEFT];
  assign rightSignal = r_out[RIGHT];
  assign upSignal    = r_out[UP];
  assign downSignal  = r_out[DOWN];

endmodule : move_ctrl
`default_nettype wire
